// File: rtl/ysyx_rf_scoreboard.sv
// ysyx_rf_scoreboard: register-busy scoreboard for the RV32E register file with same-cycle commit bypass
module ysyx_rf_scoreboard #(
    parameter int NR_REG = 16,
    parameter int CNT_W  = 2,
    parameter int OUT_W  = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      issue_valid,
    input  logic                      issue_wen,
    input  logic [$clog2(NR_REG)-1:0] issue_rd,
    output logic                      issue_ready,
    input  logic                      commit_valid,
    input  logic [$clog2(NR_REG)-1:0] commit_rd,
    input  logic                      flush,
    input  logic [$clog2(NR_REG)-1:0] rs1,
    input  logic [$clog2(NR_REG)-1:0] rs2,
    output logic [NR_REG-1:0]         rf_table,
    output logic                      rs1_busy,
    output logic                      rs2_busy,
    output logic [OUT_W-1:0]          outstanding,
    output logic                      idle,
    output logic                      err_underflow
);
    logic [CNT_W-1:0] cnt     [NR_REG];
    logic [CNT_W-1:0] cnt_nxt [NR_REG];
    logic [NR_REG-1:0] inc_hit;
    logic [NR_REG-1:0] dec_hit;
    logic issue_track;
    logic issue_fire;
    logic commit_fire;
    logic commit_dec;
    logic cnt_full;
    logic out_full;
    // Issue/commit qualification; register 0 is never tracked and a commit only decrements a nonzero count
    always_comb begin
        issue_track = issue_wen && issue_rd != '0;
        commit_fire = commit_valid && commit_rd != '0;
        commit_dec  = commit_fire && cnt[commit_rd] != '0;
        cnt_full    = cnt[issue_rd] == '1 && !(commit_fire && commit_rd == issue_rd);
        out_full    = outstanding == '1 && !commit_dec;
        issue_ready = !(issue_track && (cnt_full || out_full));
        issue_fire  = issue_valid && issue_track && issue_ready;
        inc_hit     = issue_fire ? NR_REG'(1) << issue_rd : '0;
        dec_hit     = commit_dec ? NR_REG'(1) << commit_rd : '0;
    end
    // Next per-register counts; flush wins over any same-cycle issue or commit
    always_comb begin
        for (int i = 0; i < NR_REG; i++) begin
            cnt_nxt[i] = flush ? '0 : cnt[i] + CNT_W'(inc_hit[i]) - CNT_W'(dec_hit[i]);
            rf_table[i] = i != 0 && cnt[i] != '0;
        end
    end
    // Per-register counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NR_REG; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NR_REG; i++) cnt[i] <= cnt_nxt[i];
        end
    end
    // Global in-flight counter and sticky underflow flag (flush leaves the flag alone)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            outstanding   <= '0;
            err_underflow <= 1'b0;
        end else begin
            outstanding   <= flush ? '0 : outstanding + OUT_W'(issue_fire) - OUT_W'(commit_dec);
            err_underflow <= err_underflow || (commit_fire && cnt[commit_rd] == '0);
        end
    end
    // Source stall decisions; a retiring last write releases its reader in the same cycle
    always_comb begin
        idle     = outstanding == '0;
        rs1_busy = rf_table[rs1] && !(commit_fire && commit_rd == rs1 && cnt[rs1] == CNT_W'(1));
        rs2_busy = rf_table[rs2] && !(commit_fire && commit_rd == rs2 && cnt[rs2] == CNT_W'(1));
    end
endmodule

// File: doc/ysyx_rf_scoreboard.md
Name: ysyx_rf_scoreboard

Overview:
- Register-busy scoreboard for the RV32E 16-entry register file.
- Decode marks a destination register busy when it issues a writing instruction; writeback releases it on commit.
- Produces the per-register busy vector consumed by decode hazard logic, plus rs1/rs2 stall decisions with same-cycle commit bypass.
- Sits between decode (issue side) and writeback (commit side); the pipeline flush clears it.

Parameters:
- NR_REG, 16, number of architectural registers tracked; index width is log2(NR_REG) = 4.
- CNT_W, 2, width of each per-register in-flight counter; maximum in-flight writes per register = 2^CNT_W-1 = 3.
- OUT_W, 3, width of the global outstanding counter; maximum total in-flight = 2^OUT_W-1 = 7.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- issue_valid  in  1  decode issues an instruction this cycle
- issue_wen  in  1  issued instruction writes rd
- issue_rd  in  4  destination register of issued instruction
- issue_ready  out  1  scoreboard can accept the issue
- commit_valid  in  1  writeback retires a register write this cycle
- commit_rd  in  4  register being written back
- flush  in  1  squash all in-flight writes (misprediction/trap)
- rs1  in  4  decode source 1 query
- rs2  in  4  decode source 2 query
- rf_table  out  16  bit i = register i has at least one pending write
- rs1_busy  out  1  rs1 pending after same-cycle commit bypass
- rs2_busy  out  1  rs2 pending after same-cycle commit bypass
- outstanding  out  3  total in-flight writes
- idle  out  1  outstanding == 0
- err_underflow  out  1  sticky: commit to a register whose count is 0

Behaviour:
- State: cnt[i] (CNT_W bits) per register; outstanding counter; err_underflow flop.
- Reset (rst low, async): all cnt = 0, outstanding = 0, err_underflow = 0.
  - Hence rf_table = 0, rs1_busy = rs2_busy = 0, idle = 1, issue_ready = 1.
  - Reset asserted mid-operation discards all pending state immediately.
- Register 0 is never tracked:
  - issue or commit to rd 0 has no effect on cnt or outstanding.
  - rf_table[0] = 0; rs1/rs2 = 0 is never busy.
- Issue acceptance: issue_fire = issue_valid & issue_wen & issue_rd != 0 & issue_ready.
  - issue_ready = !(cnt[issue_rd] == max & no same-cycle commit to issue_rd) & !(outstanding == max & no commit this cycle).
  - issue_ready is combinational from state, commit_valid/commit_rd and issue_rd.
  - Issue with issue_wen = 0 or rd 0 always has issue_ready = 1 and changes nothing.
- Commit: commit_fire = commit_valid & commit_rd != 0.
  - If cnt[commit_rd] == 0: counter unchanged, err_underflow sets to 1 (sticky until reset).
- Counter update at posedge:
  - cnt[r] += issue_fire hit r; cnt[r] -= commit_fire hit r with cnt[r] > 0.
  - Simultaneous issue and commit to the same r: cnt[r] unchanged.
  - outstanding is updated by the same rule using the valid commit decrement.
- Flush has priority: next-cycle cnt = 0 and outstanding = 0, ignoring any same-cycle issue/commit; err_underflow is unaffected.
- rf_table[i] = (cnt[i] != 0), registered view only (no bypass); one-cycle latency from issue to visible bit.
- rsX_busy = rf_table[rsX] & !(commit_fire & commit_rd == rsX & cnt[rsX] == 1).
  - A last pending write retiring this cycle releases the stall in the same cycle.
  - A same-cycle issue to rsX does not affect rsX_busy in that cycle.
- No arithmetic wrap: saturation is prevented by issue_ready; underflow is prevented and flagged.

Test Plan:
- Reset then idle: rst low 2 cycles, release -> rf_table=0, outstanding=0, idle=1, issue_ready=1, err_underflow=0.
- Single write lifecycle: issue rd=5 cycle 0.
  - Cycle 1: rf_table=0x0020, rs1=5 gives rs1_busy=1.
  - commit rd=5 in cycle 3: rs1_busy=0 same cycle; rf_table=0 in cycle 4; idle=1.
- Saturation: issue rd=3 three times -> cnt=3, issue_ready=0 for rd=3 (still 1 for rd=4).
  - Same cycle commit rd=3 plus issue rd=3 -> issue_ready=1, cnt stays 3.
- Global limit: 7 issues to rd 1..7 -> outstanding=7, issue_ready=0 for rd=8; one commit -> outstanding=6, issue_ready=1.
- Flush priority: pending rd 2,9; assert flush together with issue rd=4 and commit rd=2 -> next cycle rf_table=0, outstanding=0, idle=1.
- rd 0 and underflow: issue rd=0 -> no change; commit rd=6 with cnt=0 -> err_underflow=1, stays 1 through later traffic until reset.
